// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the sequencer and the datapath (CYCLE_CNT/INSTR_CNT present only with MULTICYCLE_CTRL_PERF_EN)
interface multicycle_control_if;
    logic [5:0] opcode;
    logic Zero, MEM_READY;
    logic PCWrite, PCWriteCond, PC_EN, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic ILLEGAL_OP;
    logic [3:0] STATE;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] CYCLE_CNT, INSTR_CNT;
`endif
    modport master(
        input  opcode, Zero, MEM_READY,
        output PCWrite, PCWriteCond, PC_EN, IorD, MemRead, MemWrite, IRWrite,
        output MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        output ILLEGAL_OP, STATE
`ifdef MULTICYCLE_CTRL_PERF_EN
        , output CYCLE_CNT, INSTR_CNT
`endif
    );
    modport slave(
        output opcode, Zero, MEM_READY,
        input  PCWrite, PCWriteCond, PC_EN, IorD, MemRead, MemWrite, IRWrite,
        input  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        input  ILLEGAL_OP, STATE
`ifdef MULTICYCLE_CTRL_PERF_EN
        , input CYCLE_CNT, INSTR_CNT
`endif
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS sequencer (Moore FSM, Mealy memory gating); MULTICYCLE_CTRL_PERF_EN adds cycle/instruction counters
module multicycle_control (
    input logic CLK,
    input logic RESET,
    multicycle_control_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd8;
    localparam logic [5:0] OP_J     = 6'd2;
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9
    } state_t;
    state_t state_q, state_d;
    logic rdy, legal;
    assign rdy = bus.MEM_READY;
    assign legal = bus.opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = rdy ? DECODE : FETCH;
            DECODE:  state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                               bus.opcode == OP_RTYPE ? EXEC :
                               bus.opcode == OP_BEQ ? BRANCH :
                               bus.opcode == OP_J ? JUMP : FETCH;
            MEMADR:  state_d = bus.opcode == OP_LW ? MEMRD : bus.opcode == OP_SW ? MEMWR : FETCH;
            MEMRD:   state_d = rdy ? MEMWB : MEMRD;
            MEMWR:   state_d = rdy ? FETCH : MEMWR;
            EXEC:    state_d = RWB;
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge CLK) state_q <= RESET ? state_d : FETCH;
    // every output is forced low while reset is held, independent of the stored state
    always_comb begin
        bus.PCWrite = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD = 1'b0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegDst = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = 2'b00;
        bus.ALUOp = 2'b00;
        bus.PCSource = 2'b00;
        bus.ILLEGAL_OP = 1'b0;
        if (RESET) begin
            case (state_q)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = rdy;
                    bus.PCWrite = rdy;
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.ILLEGAL_OP = !legal;
                end
                MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD = 1'b1;
                end
                MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD = 1'b1;
                end
                EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp = 2'b10;
                end
                RWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst = 1'b1;
                end
                BRANCH: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource = 2'b01;
                end
                JUMP: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end
    assign bus.PC_EN = bus.PCWrite | (bus.PCWriteCond & bus.Zero);
    assign bus.STATE = RESET ? state_q : 4'd0;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cyc_q, cyc_d, ins_q, ins_d;
    logic done;
    always_comb begin
        done = state_q inside {MEMWB, RWB, BRANCH, JUMP} || (state_q == MEMWR && rdy);
        cyc_d = cyc_q + 32'd1;
        ins_d = ins_q + {31'd0, done};
    end
    always_ff @(posedge CLK) begin
        cyc_q <= RESET ? cyc_d : 32'd0;
        ins_q <= RESET ? ins_d : 32'd0;
    end
    assign bus.CYCLE_CNT = cyc_q;
    assign bus.INSTR_CNT = ins_q;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level randomized bench for multicycle_control (counters checked when MULTICYCLE_CTRL_PERF_EN is defined)
module tb_multicycle_control;
    typedef struct packed {
        logic pcw, pcwc, pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic ill;
    } ctl_t;
    logic CLK = 1'b0;
    logic RESET;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] cyc_m = 0, ins_m = 0;
    logic cnt_ok = 1'b0;
    always #5 CLK = ~CLK;
    multicycle_control_if bus();
    multicycle_control dut(.CLK(CLK), .RESET(RESET), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic ctl_t obs();
        return {bus.PCWrite, bus.PCWriteCond, bus.PC_EN, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.ILLEGAL_OP};
    endfunction
    function automatic logic is_legal(input logic [5:0] op);
        return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd8 || op == 6'd2;
    endfunction
    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction
    task automatic step(input logic rn, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [3:0] es, input ctl_t eo, input logic fin);
        logic bad;
        @(negedge CLK);
        RESET = rn;
        bus.opcode = op;
        bus.Zero = z;
        bus.MEM_READY = rdy;
        #1;
        chk("state", {28'd0, bus.STATE}, {28'd0, es});
        chk("ctl", {13'd0, obs()}, {13'd0, eo});
        bad = (int'(bus.RegWrite) + int'(bus.MemWrite) + int'(bus.IRWrite) > 1) || (bus.MemRead && bus.MemWrite);
        chk("excl", {31'd0, bad}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        if (cnt_ok) begin
            chk("cycle_cnt", bus.CYCLE_CNT, cyc_m);
            chk("instr_cnt", bus.INSTR_CNT, ins_m);
        end
`endif
        if (!rn) begin
            cyc_m = 0;
            ins_m = 0;
            cnt_ok = 1'b1;
        end else begin
            cyc_m++;
            ins_m += {31'd0, fin};
        end
    endtask
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        ctl_t e;
        for (int i = 0; i <= fw; i++) begin
            e = '0;
            e.mrd = 1'b1;
            e.srcb = 2'b01;
            if (i == fw) begin
                e.irw = 1'b1;
                e.pcw = 1'b1;
                e.pcen = 1'b1;
            end
            step(1'b1, 6'($urandom), rb(), i == fw, 4'd0, e, 1'b0);
        end
        e = '0;
        e.srcb = 2'b11;
        e.ill = !is_legal(op);
        step(1'b1, op, rb(), rb(), 4'd1, e, 1'b0);
        if (op == 6'd35 || op == 6'd43) begin
            e = '0;
            e.srca = 1'b1;
            e.srcb = 2'b10;
            step(1'b1, op, rb(), rb(), 4'd2, e, 1'b0);
            for (int i = 0; i <= mw; i++) begin
                e = '0;
                e.iord = 1'b1;
                if (op == 6'd35) e.mrd = 1'b1;
                else e.mwr = 1'b1;
                step(1'b1, op, rb(), i == mw, op == 6'd35 ? 4'd3 : 4'd5, e, op == 6'd43 && i == mw);
            end
            if (op == 6'd35) begin
                e = '0;
                e.rw = 1'b1;
                e.m2r = 1'b1;
                step(1'b1, op, rb(), rb(), 4'd4, e, 1'b1);
            end
        end else if (op == 6'd0) begin
            e = '0;
            e.srca = 1'b1;
            e.aluop = 2'b10;
            step(1'b1, op, rb(), rb(), 4'd6, e, 1'b0);
            e = '0;
            e.rw = 1'b1;
            e.rdst = 1'b1;
            step(1'b1, op, rb(), rb(), 4'd7, e, 1'b1);
        end else if (op == 6'd8) begin
            e = '0;
            e.srca = 1'b1;
            e.aluop = 2'b01;
            e.pcwc = 1'b1;
            e.pcsrc = 2'b01;
            e.pcen = z;
            step(1'b1, op, z, rb(), 4'd8, e, 1'b1);
        end else if (op == 6'd2) begin
            e = '0;
            e.pcw = 1'b1;
            e.pcen = 1'b1;
            e.pcsrc = 2'b10;
            step(1'b1, op, rb(), rb(), 4'd9, e, 1'b1);
        end
    endtask
    initial begin
        ctl_t e;
        logic [5:0] op;
        logic [5:0] ops [5];
        ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd8; ops[4] = 6'd2;
        RESET = 1'b0;
        bus.opcode = 6'd0;
        bus.Zero = 1'b0;
        bus.MEM_READY = 1'b0;
        step(1'b0, 6'd0, 1'b1, 1'b1, 4'd0, '0, 1'b0);
        step(1'b0, 6'd35, 1'b1, 1'b1, 4'd0, '0, 1'b0);
        run_instr(6'd0, 0, 0, 1'b0);
        run_instr(6'd35, 0, 3, 1'b0);
        run_instr(6'd8, 0, 0, 1'b1);
        run_instr(6'd8, 0, 0, 1'b0);
        run_instr(6'd2, 2, 0, 1'b0);
        run_instr(6'h3F, 0, 0, 1'b0);
        run_instr(6'd43, 1, 2, 1'b0);
        e = '0;
        e.mrd = 1'b1;
        e.srcb = 2'b01;
        e.irw = 1'b1;
        e.pcw = 1'b1;
        e.pcen = 1'b1;
        step(1'b1, 6'd0, 1'b0, 1'b1, 4'd0, e, 1'b0);
        e = '0;
        e.srcb = 2'b11;
        step(1'b1, 6'd0, 1'b0, 1'b0, 4'd1, e, 1'b0);
        e = '0;
        e.srca = 1'b1;
        e.aluop = 2'b10;
        step(1'b1, 6'd0, 1'b1, 1'b1, 4'd6, e, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b1, 4'd0, '0, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b1, 4'd0, '0, 1'b0);
        run_instr(6'd0, 0, 0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 7) == 0 ? 6'($urandom) : ops[$urandom_range(0, 4)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb());
            if ($urandom_range(0, 40) == 0) step(1'b0, 6'($urandom), rb(), rb(), 4'd0, '0, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath: register file, ALU/ALUControl, sign-extend/shift, branch/jump muxes, PC and data memory. It replaces the single-cycle CONTROL decoder with a Moore FSM, plus Mealy gating on memory handshakes. Instructions are split into FETCH/DECODE/EXEC/MEM/WB steps so one ALU and one memory port are shared across cycles. It sits between INSTRUCTION_REGISTER (opcode) / MIPSALU (Zero) and every datapath enable and mux select.

Parameters:
OP_RTYPE, 6'd0, R-type opcode
OP_LW, 6'd35, load word opcode
OP_SW, 6'd43, store word opcode
OP_BEQ, 6'd8, branch-equal opcode (codebase encoding)
OP_J, 6'd2, jump opcode

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  synchronous, active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
Zero  in  1  ALU zero flag
MEM_READY  in  1  memory handshake; access completes in a cycle with MemRead|MemWrite=1 and MEM_READY=1
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if Zero
PC_EN  out  1  PCWrite | (PCWriteCond & Zero)
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  1  1=memory data to register write port, 0=ALUOut
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=signext, 11=signext<<2
ALUOp  out  2  to ALUControl (00 add, 01 sub, 10 funct)
PCSource  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
ILLEGAL_OP  out  1  one-cycle pulse on unknown opcode
STATE  out  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9. Codes 10-15 are unreachable; if entered, go to FETCH next cycle.
- Reset: RESET=0 at a rising edge forces STATE=FETCH. This applies mid-instruction and overrides all other transitions.
- While RESET=0, all outputs are 0 and STATE=0. Decode outputs from STATE only when RESET=1.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=MEM_READY (Mealy). Stay in FETCH while MEM_READY=0; go to DECODE on MEM_READY=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - other -> FETCH, with ILLEGAL_OP=1 in this DECODE cycle only.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: LW -> MEMRD, SW -> MEMWR (opcode re-sampled; IR is stable).
- MEMRD: MemRead=1, IorD=1. Hold until MEM_READY=1, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next state: FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MEM_READY=1, then go to FETCH. MemWrite stays high and stable for the whole wait (no glitch).
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. PC_EN=Zero in this cycle. Next state: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state: FETCH.
- Latency with MEM_READY tied high:
  - R-type 4 cycles, LW 5, SW 4, BEQ 3, J 3, illegal 2.
  - Each memory wait cycle adds 1.
- Write enables are mutually exclusive:
  - RegWrite, MemWrite and IRWrite are never high together.
  - MemRead and MemWrite are never high together.
- MEM_READY outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
Macro MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - adds outputs CYCLE_CNT[31:0] and INSTR_CNT[31:0], both cleared by reset.
  - CYCLE_CNT increments every non-reset cycle.
  - INSTR_CNT increments on each completed instruction: the last cycle of MEMWB, MEMWR (with MEM_READY), RWB, BRANCH or JUMP.
  - Illegal opcodes do not count.
  - Both counters wrap 0xFFFFFFFF -> 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: RESET=0 for 2 cycles mid-EXEC, then RESET=1 -> STATE=0, all outputs 0 during reset; FETCH with MemRead=1 on the first cycle after release.
- R-type: MEM_READY=1, opcode=0 -> STATE sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; ALUOp=10 in state 6.
- LW with wait: opcode=35, MEM_READY low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; MemRead and IorD held at 1 for 4 cycles; RegWrite with MemtoReg=1 in state 4.
- BEQ: opcode=8 with Zero=1 -> PC_EN=1, PCSource=01 in state 8. Repeat with Zero=0 -> PC_EN=0; returns to FETCH either way.
- Fetch stall and jump: MEM_READY=0 for 2 cycles in FETCH -> IRWrite and PCWrite stay 0 until MEM_READY=1, then pulse 1 cycle. Then opcode=2 -> JUMP with PCWrite=1, PCSource=10.
- Illegal opcode: opcode=6'h3F -> ILLEGAL_OP=1 for exactly 1 cycle in DECODE, next STATE=0. With MULTICYCLE_CTRL_PERF_EN, INSTR_CNT unchanged and CYCLE_CNT +2.
